front_panel_ctrl: RTL and testbench
===================================

# front_panel_ctrl

Parametrised board front-panel controller sitting between the FPGA pins (switches, raw push-buttons, LEDs) and the `flow` core plus its hex-display decoders. Debounces and edge-detects the keys, assembles a multi-byte switch register one byte per load, selects one SLICE_W-wide window of a wide debug bus for the hex displays, and drives the LED view. It adds an optional timed auto-scroll through the debug bus.

## Interface
Parameters:
- SLICE_W, 16, width of displayed window; multiple of 4
- NUM_SLICES, 32, number of windows in `display`; power of 2, 2..32
- SW_BYTES, 2, switch register width in bytes (SWITCH_W = 8*SW_BYTES), 1..8
- DEBOUNCE_CYCLES, 500000, stable cycles required before a key change is accepted; ≥1
- SCROLL_CYCLES, 25000000, auto-scroll period in clocks; ≥2

Ports (OFF_W = clog2(NUM_SLICES)):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- sw  in  10  slide switches, treated as synchronous
- key_n  in  4  raw active-low buttons, asynchronous; [1] load, [2] user step, [3] switch clock; [0] ignored
- display  in  NUM_SLICES*SLICE_W  debug bus
- flags  in  16  status flags
- slice  out  SLICE_W  `display[SLICE_W*offset +: SLICE_W]`, combinational
- offset  out  OFF_W  current window index
- switch_register  out  SWITCH_W  assembled switch value
- clock_lock  out  1  latched clock-lock mode
- user_step  out  1  one-cycle pulse per accepted key_n[2] press
- switch_clock  out  1  one-cycle pulse per accepted key_n[3] press
- led  out  10  LED view

## Operation
- Modes: `special = sw[9]`, `top_select = sw[8]`.
- Each key: 2-flop synchroniser, then debouncer: counter resets whenever synced level ≠ debounced state; when it reaches DEBOUNCE_CYCLES, debounced state takes synced level. Press event = debounced state idle→pressed.
- Load event, `special = 0`: byte `byte_ptr` of switch_register ← sw[7:0]; byte_ptr ← (byte_ptr+1) mod SW_BYTES.
- Load event, `special = 1`: if sw[4:0] < NUM_SLICES, offset ← sw[OFF_W-1:0], range_err ← 0; else offset unchanged, range_err ← 1. clock_lock ← sw[5] in both cases.
- user_step / switch_clock: pulse for the press-event cycle only; held keys give one pulse.
- led[7:0] = special ? (top_select ? flags[15:8] : flags[7:0]) : switch_register byte at byte_ptr. led[8] = clock_lock; led[9] = range_err.
- Reset values: switch_register 0, byte_ptr 0, offset 0, clock_lock 0, range_err 0, pulses 0, debounced state released, all counters 0.

## Timing
- key_n falling before edge 0 and held: synced low after edge 2; debounced state changes at edge 2+DEBOUNCE_CYCLES; pulse and register updates take effect at edge 3+DEBOUNCE_CYCLES, high/visible for exactly one cycle (pulse) or from then on (registers).
- Bounce shorter than DEBOUNCE_CYCLES: no event. Release uses same filter; no event on release.
- byte_ptr wraps SW_BYTES-1 → 0. SW_BYTES = 1: byte_ptr stays 0.
- Mode change on the event edge: sw sampled on that edge decides.
- Reset asserted mid-debounce: counters clear; key must be re-qualified for a full DEBOUNCE_CYCLES after release of reset.

## Configuration
- FRONT_PANEL_AUTOSCROLL_EN defined: when `special = 1` and sw[6] = 1, offset increments every SCROLL_CYCLES clocks, wrapping NUM_SLICES-1 → 0; scroll counter clears when sw[6] = 0 or special = 0. A load event in the same cycle as a scroll tick wins and clears the scroll counter.
- Undefined: sw[6] ignored; offset changes only on load events; no scroll counter logic.

## Structure
- Shared package `flow_panel_pkg`: key index constants (KEY_LOAD=1, KEY_STEP=2, KEY_SWCLK=3), sw bit constants (SW_SPECIAL=9, SW_TOP=8, SW_SCROLL=6, SW_LOCK=5).
- One sub-module `key_debounce` (sync + counter + edge detect, parameter DEBOUNCE_CYCLES), instantiated three times.

## Test plan
(Bench: DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8, defaults otherwise.)
- Reset, then idle -> all outputs 0, led = 0, slice = display[15:0].
- special=0, sw[7:0]=0xAB, clean load press; then sw[7:0]=0xCD, second press -> switch_register 0x00AB after edge 7, then 0xCDAB; byte_ptr back to 0, led[7:0]=0xAB.
- key_n[2] bounces low for 3 cycles, then held low 20 cycles -> exactly one user_step pulse, 7 edges after stable low begins.
- special=1, sw[4:0]=5, sw[5]=1, load -> offset 5, slice = display[95:80], led[8]=1; NUM_SLICES=16 build with sw[4:0]=20 -> offset unchanged, led[9]=1.
- AUTOSCROLL_EN build, special=1, sw[6]=1, offset 31 -> offset 0 after 8 clocks, 1 after 16; load on tick edge with sw[4:0]=3 -> offset 3.
- Reset asserted after 2 debounce cycles of a held load -> no switch_register change; pulse occurs 7 edges after reset release.

Source files
------------

// File: rtl/flow_panel_pkg.sv
// flow_panel_pkg: key and switch bit positions shared by the front-panel logic.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package flow_panel_pkg;

  // Bit positions within key_n
  localparam int KEY_LOAD  = 1;
  localparam int KEY_STEP  = 2;
  localparam int KEY_SWCLK = 3;

  // Bit positions within sw
  localparam int SW_SPECIAL = 9;
  localparam int SW_TOP     = 8;
  localparam int SW_SCROLL  = 6;
  localparam int SW_LOCK    = 5;

  // Pick the upper or lower status-flag byte for the LED view
  function automatic logic [7:0] flag_byte(input logic top, input logic [15:0] flags);
    return top ? flags[15:8] : flags[7:0];
  endfunction

endpackage

// File: rtl/front_panel_ctrl_key_debounce.sv
// key_debounce: 2-flop synchroniser, stability counter and press-edge detector for one raw key.
// Latency: press_o is high 2+DEBOUNCE_CYCLES clocks after a clean falling key_n_i, for one cycle.
// Backpressure: none; one press_o pulse per accepted idle->pressed transition, none on release.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             prev_q;

  // Synchronise the inverted (active-high "pressed") key level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], ~key_n_i};
  end

  assign synced = sync_q[1];

  // Count consecutive cycles the synced level disagrees with the debounced state
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (synced != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) deb_d = synced;
      else                                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounced state, counter and one-cycle-delayed copy for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      prev_q <= deb_q;
    end
  end

  assign press_o = deb_q & ~prev_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// front_panel_ctrl: debounced keys, byte-wise switch register, debug-window select and LED view.
// Latency: key press -> pulse/register update 3+DEBOUNCE_CYCLES clocks; slice and led are combinational.
// Backpressure: none; FRONT_PANEL_AUTOSCROLL_EN adds a timed offset scroll in special mode.
module front_panel_ctrl
  import flow_panel_pkg::*;
#(
  parameter  int SLICE_W         = 16,
  parameter  int NUM_SLICES      = 32,
  parameter  int SW_BYTES        = 2,
  parameter  int DEBOUNCE_CYCLES = 500000,
  parameter  int SCROLL_CYCLES   = 25000000,
  localparam int OFF_W           = $clog2(NUM_SLICES),
  localparam int SWITCH_W        = 8 * SW_BYTES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [9:0]                    sw,
  input  logic [3:0]                    key_n,
  input  logic [NUM_SLICES*SLICE_W-1:0] display,
  input  logic [15:0]                   flags,
  output logic [SLICE_W-1:0]            slice,
  output logic [OFF_W-1:0]              offset,
  output logic [SWITCH_W-1:0]           switch_register,
  output logic                          clock_lock,
  output logic                          user_step,
  output logic                          switch_clock,
  output logic [9:0]                    led
);

  localparam int PTR_W = (SW_BYTES > 1) ? $clog2(SW_BYTES) : 1;

  logic load_press, step_press, swclk_press;
  logic special, top_select, in_range;

  logic [SWITCH_W-1:0] sr_q, sr_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic                lock_q, lock_d;
  logic                rerr_q, rerr_d;
  logic                step_q, swclk_q;
  logic [7:0]          cur_byte;
  logic                scroll_tick;

  logic [NUM_SLICES-1:0][SLICE_W-1:0] disp_arr;

  // key_n[0] has no function on this board
  logic unused_key0;
  assign unused_key0 = key_n[0];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_load (
    .clk_i(clock), .rst_i(reset), .key_n_i(key_n[KEY_LOAD]),  .press_o(load_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
    .clk_i(clock), .rst_i(reset), .key_n_i(key_n[KEY_STEP]),  .press_o(step_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_swclk (
    .clk_i(clock), .rst_i(reset), .key_n_i(key_n[KEY_SWCLK]), .press_o(swclk_press));

  assign special    = sw[SW_SPECIAL];
  assign top_select = sw[SW_TOP];
  assign in_range   = ({1'b0, sw[4:0]} < 6'(NUM_SLICES));

`ifdef FRONT_PANEL_AUTOSCROLL_EN
  localparam int SCR_W = $clog2(SCROLL_CYCLES);

  logic             scroll_en;
  logic [SCR_W-1:0] scroll_cnt_q, scroll_cnt_d;

  assign scroll_en   = special & sw[SW_SCROLL];
  assign scroll_tick = scroll_en && (scroll_cnt_q == SCR_W'(SCROLL_CYCLES - 1));

  // Scroll period counter; idle at zero whenever scrolling is off
  always_comb begin
    scroll_cnt_d = scroll_cnt_q + SCR_W'(1);
    if (!scroll_en || scroll_tick) scroll_cnt_d = '0;
  end

  // Scroll counter state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) scroll_cnt_q <= '0;
    else       scroll_cnt_q <= scroll_cnt_d;
  end
`else
  assign scroll_tick = 1'b0;
`endif

  // Normal-mode load writes the byte under the pointer and advances it
  always_comb begin
    sr_d  = sr_q;
    ptr_d = ptr_q;
    if (load_press && !special) begin
      for (int i = 0; i < SW_BYTES; i++) begin
        if (ptr_q == PTR_W'(i)) sr_d[8*i +: 8] = sw[7:0];
      end
      if (ptr_q == PTR_W'(SW_BYTES - 1)) ptr_d = '0;
      else                               ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Special-mode load sets window, lock and range error; a load beats a scroll tick
  always_comb begin
    offset_d = offset_q;
    lock_d   = lock_q;
    rerr_d   = rerr_q;
    if (scroll_tick) offset_d = offset_q + OFF_W'(1);
    if (load_press && special) begin
      lock_d = sw[SW_LOCK];
      if (in_range) begin
        offset_d = sw[OFF_W-1:0];
        rerr_d   = 1'b0;
      end else begin
        offset_d = offset_q;
        rerr_d   = 1'b1;
      end
    end
  end

  // Panel state and registered key pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q     <= '0;
      ptr_q    <= '0;
      offset_q <= '0;
      lock_q   <= 1'b0;
      rerr_q   <= 1'b0;
      step_q   <= 1'b0;
      swclk_q  <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      ptr_q    <= ptr_d;
      offset_q <= offset_d;
      lock_q   <= lock_d;
      rerr_q   <= rerr_d;
      step_q   <= step_press;
      swclk_q  <= swclk_press;
    end
  end

  // Byte of the switch register that the next load will overwrite
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < SW_BYTES; i++) begin
      if (ptr_q == PTR_W'(i)) cur_byte = sr_q[8*i +: 8];
    end
  end

  assign disp_arr = display;
  assign slice    = disp_arr[offset_q];

  assign offset          = offset_q;
  assign switch_register = sr_q;
  assign clock_lock      = lock_q;
  assign user_step       = step_q;
  assign switch_clock    = swclk_q;
  assign led             = {rerr_q, lock_q, special ? flag_byte(top_select, flags) : cur_byte};

endmodule

// File: tb/tb_front_panel_ctrl.sv
// tb_front_panel_ctrl: directed checks of key qualification, switch loads, window select and LEDs.
// Latency: n/a.
// Backpressure: n/a.
module tb_front_panel_ctrl;

  logic         clock;
  logic         reset;
  logic [9:0]   sw;
  logic [3:0]   key_n;
  logic [511:0] display32;
  logic [255:0] display16;
  logic [15:0]  flags;

  logic [15:0] slice32, slice16;
  logic [4:0]  offset32;
  logic [3:0]  offset16;
  logic [15:0] sr32, sr16;
  logic        lock32, lock16, step32, step16, swclk32, swclk16;
  logic [9:0]  led32, led16;

  int tests_run    = 0;
  int tests_failed = 0;

  front_panel_ctrl #(.DEBOUNCE_CYCLES(4), .SCROLL_CYCLES(8)) u_dut (
    .clock(clock), .reset(reset), .sw(sw), .key_n(key_n), .display(display32), .flags(flags),
    .slice(slice32), .offset(offset32), .switch_register(sr32), .clock_lock(lock32),
    .user_step(step32), .switch_clock(swclk32), .led(led32));

  front_panel_ctrl #(.NUM_SLICES(16), .DEBOUNCE_CYCLES(4), .SCROLL_CYCLES(8)) u_dut16 (
    .clock(clock), .reset(reset), .sw(sw), .key_n(key_n), .display(display16), .flags(flags),
    .slice(slice16), .offset(offset16), .switch_register(sr16), .clock_lock(lock16),
    .user_step(step16), .switch_clock(swclk16), .led(led16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;
    int first;

    for (int i = 0; i < 32; i++) display32[16*i +: 16] = 16'h5A00 + 16'(i);
    display16 = display32[255:0];
    flags = 16'hC33C;
    sw    = 10'h000;
    key_n = 4'hF;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(3);

    // Reset / idle state
    check("rst_sr",     32'(sr32),     32'h0);
    check("rst_offset", 32'(offset32), 32'h0);
    check("rst_lock",   32'(lock32),   32'h0);
    check("rst_step",   32'(step32),   32'h0);
    check("rst_swclk",  32'(swclk32),  32'h0);
    check("rst_led",    32'(led32),    32'h0);
    check("rst_slice",  32'(slice32),  32'h5A00);

    // Two normal-mode loads fill bytes 0 then 1, pointer wraps
    sw = 10'h0AB;
    key_n[1] = 1'b0;
    step(7);
    check("load1_early", 32'(sr32), 32'h0);
    step(1);
    check("load1_sr",  32'(sr32),  32'h00AB);
    check("load1_led", 32'(led32), 32'h000);
    key_n[1] = 1'b1;
    step(10);
    sw = 10'h0CD;
    key_n[1] = 1'b0;
    step(8);
    check("load2_sr",  32'(sr32),  32'hCDAB);
    check("load2_led", 32'(led32), 32'h0AB);
    key_n[1] = 1'b1;
    step(10);

    // Bouncy user-step key: one pulse, 7 edges after stable low begins
    pulses = 0;
    first  = -1;
    key_n[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1); if (step32) pulses++; end
    key_n[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin step(1); if (step32) pulses++; end
    key_n[2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (step32) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("step_pulses", 32'(pulses), 32'd1);
    check("step_when",   32'(first),  32'd8);
    key_n[2] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin step(1); if (step32) pulses++; end
    check("step_release", 32'(pulses), 32'd0);

    // Switch-clock key: single pulse, no user_step
    pulses = 0;
    first  = -1;
    key_n[3] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (swclk32) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (step32) pulses += 100;
    end
    check("swclk_pulses", 32'(pulses), 32'd1);
    check("swclk_when",   32'(first),  32'd8);
    key_n[3] = 1'b1;
    step(10);

    // Special load: offset 5 with lock
    sw = 10'h225;
    key_n[1] = 1'b0;
    step(8);
    check("sp_offset",  32'(offset32), 32'd5);
    check("sp_slice",   32'(slice32),  32'h5A05);
    check("sp_led_lo",  32'(led32),    32'h13C);
    check("sp_sr_keep", 32'(sr32),     32'hCDAB);
    check("sp16_offset", 32'(offset16), 32'd5);
    sw = 10'h325;
    #1;
    check("sp_led_hi", 32'(led32), 32'h1C3);
    key_n[1] = 1'b1;
    step(10);

    // Offset 20: valid for 32 slices, out of range for 16
    sw = 10'h214;
    key_n[1] = 1'b0;
    step(8);
    check("sp20_offset",   32'(offset32), 32'd20);
    check("sp20_slice",    32'(slice32),  32'h5A14);
    check("sp20_led",      32'(led32),    32'h03C);
    check("sp16_keep",     32'(offset16), 32'd5);
    check("sp16_led_rerr", 32'(led16),    32'h23C);
    check("sp16_slice",    32'(slice16),  32'h5A05);
    key_n[1] = 1'b1;
    step(10);

`ifdef FRONT_PANEL_AUTOSCROLL_EN
    // Auto-scroll wraps 31 -> 0 -> 1; a load on the tick edge wins
    sw = 10'h21F;
    key_n[1] = 1'b0;
    step(8);
    check("as_offset31", 32'(offset32), 32'd31);
    key_n[1] = 1'b1;
    step(10);
    sw = 10'h25F;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 7)  check("as_before_tick", 32'(offset32), 32'd31);
      if (i == 8)  check("as_wrap",        32'(offset32), 32'd0);
      if (i == 16) check("as_second",      32'(offset32), 32'd1);
    end
    sw = 10'h243;
    key_n[1] = 1'b0;
    step(7);
    check("as_pre_load", 32'(offset32), 32'd1);
    step(1);
    check("as_load_wins", 32'(offset32), 32'd3);
    step(8);
    check("as_after_load", 32'(offset32), 32'd4);
    sw = 10'h200;
    key_n[1] = 1'b1;
    step(10);
`endif

    // Reset during debounce of a held load key requalifies from scratch
    sw = 10'h011;
    key_n[1] = 1'b0;
    step(4);
    reset = 1'b1;
    step(2);
    check("mid_rst_sr",     32'(sr32),     32'h0);
    check("mid_rst_offset", 32'(offset32), 32'h0);
    reset = 1'b0;
    step(7);
    check("rel_early", 32'(sr32), 32'h0);
    step(1);
    check("rel_load", 32'(sr32), 32'h0011);
    sw = 10'h022;
    step(10);
    check("held_once", 32'(sr32), 32'h0011);
    key_n[1] = 1'b1;
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
